// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment readback path.
// Segment order is abcdefg with bit6 = a, active high.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] BCD_BLANK = 4'hE;
    localparam logic [3:0] BCD_ERR   = 4'hF;

    typedef enum logic {
        COLLECT,
        PRESENT
    } frame_state_e;

endpackage

// File: rtl/display_scan_reader_if.sv
// Display bus in, frame handshake out.
// slave = the reader, master = the display/consumer side.
interface display_scan_reader_if #(
    parameter int NUM_DIGITS = 4
) ();

    logic [6:0]              seg;
    logic [NUM_DIGITS-1:0]   dig_en;
    logic [4*NUM_DIGITS-1:0] frame_bcd;
    logic [NUM_DIGITS-1:0]   frame_err;
    logic                    frame_valid;
    logic                    frame_ready;
    logic                    overrun;

    modport master (
        output seg,
        output dig_en,
        output frame_ready,
        input  frame_bcd,
        input  frame_err,
        input  frame_valid,
        input  overrun
    );

    modport slave (
        input  seg,
        input  dig_en,
        input  frame_ready,
        output frame_bcd,
        output frame_err,
        output frame_valid,
        output overrun
    );

endinterface

// File: rtl/seg7_to_bcd.sv
// Inverse of the BCD-to-7-segment decoder.
// Blank maps to E; anything unrecognised maps to F with err set.
module seg7_to_bcd
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] bcd,
    output logic       err
);

    always_comb begin
        bcd = BCD_ERR;
        err = 1'b0;
        case (seg)
            SEG_0:     bcd = 4'd0;
            SEG_1:     bcd = 4'd1;
            SEG_2:     bcd = 4'd2;
            SEG_3:     bcd = 4'd3;
            SEG_4:     bcd = 4'd4;
            SEG_5:     bcd = 4'd5;
            SEG_6:     bcd = 4'd6;
            SEG_7:     bcd = 4'd7;
            SEG_8:     bcd = 4'd8;
            SEG_9:     bcd = 4'd9;
            SEG_BLANK: bcd = BCD_BLANK;
            default: begin
                bcd = BCD_ERR;
                err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/display_scan_reader.sv
// Samples a multiplexed 7-seg bus, filters each position for stability
// and presents one BCD frame per full scan on a valid/ready handshake.
module display_scan_reader
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    display_scan_reader_if.slave  bus
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   en_q, en_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    cap_q, cap_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    logic [4*NUM_DIGITS-1:0] slot_bcd_q, slot_bcd_d;
    logic [NUM_DIGITS-1:0]   slot_err_q, slot_err_d;
    logic [4*NUM_DIGITS-1:0] frame_bcd_q, frame_bcd_d;
    logic [NUM_DIGITS-1:0]   frame_err_q, frame_err_d;
    logic                    valid_q, valid_d;
    logic                    ovr_q, ovr_d;
    frame_state_e            state_q, state_d;

    logic [3:0]            code;
    logic                  code_err;
    logic                  same;
    logic                  one_hot;
    logic                  do_cap;
    logic                  full;
    logic                  hs;
    logic [NUM_DIGITS-1:0] cap_mask;

    seg7_to_bcd u_dec (
        .seg (seg_q),
        .bcd (code),
        .err (code_err)
    );

    always_comb begin
        seg_d       = bus.seg;
        en_d        = bus.dig_en;
        cnt_d       = cnt_q;
        cap_d       = cap_q;
        seen_d      = seen_q;
        slot_bcd_d  = slot_bcd_q;
        slot_err_d  = slot_err_q;
        frame_bcd_d = frame_bcd_q;
        frame_err_d = frame_err_q;
        valid_d     = valid_q;
        ovr_d       = 1'b0;
        state_d     = state_q;

        same    = (bus.seg == seg_q) && (bus.dig_en == en_q);
        one_hot = (en_q != '0) && ((en_q & (en_q - 1'b1)) == '0);
        do_cap  = (cnt_q == CNT_MAX) && one_hot && !cap_q;
        cap_mask = do_cap ? en_q : '0;
        full    = &seen_q;
        hs      = valid_q & bus.frame_ready;

        // A new sample restarts the steady window and re-arms capture
        if (same) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
            cap_d = cap_q | do_cap;
        end else begin
            cnt_d = CNT_ONE;
            cap_d = 1'b0;
        end

        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (cap_mask[i]) begin
                slot_bcd_d[4*i +: 4] = code;
                slot_err_d[i]        = code_err;
            end
        end

        seen_d = (full ? '0 : seen_q) | cap_mask;

        unique case (state_q)
            COLLECT: begin
                if (full) begin
                    frame_bcd_d = slot_bcd_q;
                    frame_err_d = slot_err_q;
                    valid_d     = 1'b1;
                    state_d     = PRESENT;
                end
            end
            PRESENT: begin
                // A handshake on the completing edge makes room for the new frame
                if (full && hs) begin
                    frame_bcd_d = slot_bcd_q;
                    frame_err_d = slot_err_q;
                end else if (full) begin
                    ovr_d = 1'b1;
                end else if (hs) begin
                    valid_d = 1'b0;
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q       <= '0;
            en_q        <= '0;
            cnt_q       <= '0;
            cap_q       <= 1'b0;
            seen_q      <= '0;
            slot_bcd_q  <= '0;
            slot_err_q  <= '0;
            frame_bcd_q <= '0;
            frame_err_q <= '0;
            valid_q     <= 1'b0;
            ovr_q       <= 1'b0;
            state_q     <= COLLECT;
        end else begin
            seg_q       <= seg_d;
            en_q        <= en_d;
            cnt_q       <= cnt_d;
            cap_q       <= cap_d;
            seen_q      <= seen_d;
            slot_bcd_q  <= slot_bcd_d;
            slot_err_q  <= slot_err_d;
            frame_bcd_q <= frame_bcd_d;
            frame_err_q <= frame_err_d;
            valid_q     <= valid_d;
            ovr_q       <= ovr_d;
            state_q     <= state_d;
        end
    end

    assign bus.frame_bcd   = frame_bcd_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.frame_valid = valid_q;
    assign bus.overrun     = ovr_q;

endmodule

// File: tb/tb_display_scan_reader.sv
// Directed and random stimulus for display_scan_reader, checked against
// a history-based reference model of the scan/frame rules.
module tb_display_scan_reader;

    localparam int N = 4;
    localparam int S = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    display_scan_reader_if #(.NUM_DIGITS(N)) bus ();

    display_scan_reader #(
        .NUM_DIGITS    (N),
        .STABLE_CYCLES (S)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors  = 0;
    int checks  = 0;
    int ovr_cnt = 0;

    logic [6:0] digit_pat [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                   7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

    logic [10:0]  hist [$];
    logic [15:0]  m_sbcd;
    logic [3:0]   m_serr;
    logic [3:0]   m_seen;
    logic [15:0]  m_bcd;
    logic [3:0]   m_err;
    logic         m_valid;
    logic         m_ovr;

    function automatic logic [4:0] enc(input logic [6:0] s);
        for (int d = 0; d < 10; d++)
            if (digit_pat[d] == s) return {4'(d), 1'b0};
        if (s == 7'h00) return {4'hE, 1'b0};
        return {4'hF, 1'b1};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_sbcd  = '0;
        m_serr  = '0;
        m_seen  = '0;
        m_bcd   = '0;
        m_err   = '0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
    endtask

    // A position is captured exactly S edges after a new steady value
    // first appears, provided it stayed put for those S samples.
    task automatic model_edge(input logic [6:0] s, input logic [3:0] e,
                              input logic r);
        logic [10:0] st;
        logic [10:0] pv;
        logic        ok;
        logic        cap;
        logic [4:0]  code;
        int          n;
        cap = 1'b0;
        st  = '0;
        n   = hist.size();
        if (n >= S) begin
            st = hist[n-S];
            ok = 1'b1;
            for (int k = n - S; k < n; k++)
                if (hist[k] != st) ok = 1'b0;
            pv  = (n > S) ? hist[n-S-1] : 11'd0;
            cap = ok && (pv != st) && $onehot(st[3:0]);
        end
        m_ovr = 1'b0;
        if (m_seen == 4'hF) begin
            if (!m_valid || r) begin
                m_bcd   = m_sbcd;
                m_err   = m_serr;
                m_valid = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
            m_seen = '0;
        end else if (m_valid && r) begin
            m_valid = 1'b0;
        end
        if (cap) begin
            code = enc(st[10:4]);
            for (int i = 0; i < N; i++) begin
                if (st[i]) begin
                    m_sbcd[4*i +: 4] = code[4:1];
                    m_serr[i]        = code[0];
                    m_seen[i]        = 1'b1;
                end
            end
        end
        hist.push_back({s, e});
        if (hist.size() > S + 1) void'(hist.pop_front());
    endtask

    task automatic cyc(input logic [6:0] s, input logic [3:0] e,
                       input logic r);
        bus.seg         = s;
        bus.dig_en      = e;
        bus.frame_ready = r;
        @(posedge clk);
        model_edge(s, e, r);
        #1;
        ovr_cnt += int'(bus.overrun);
        chk("bcd",   32'(bus.frame_bcd),   32'(m_bcd));
        chk("err",   32'(bus.frame_err),   32'(m_err));
        chk("valid", 32'(bus.frame_valid), 32'(m_valid));
        chk("ovr",   32'(bus.overrun),     32'(m_ovr));
    endtask

    task automatic hold(input logic [6:0] s, input logic [3:0] e,
                        input int len, input logic r);
        for (int c = 0; c < len; c++) cyc(s, e, r);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_bcd"},   32'(bus.frame_bcd),   32'd0);
        chk({tag, "_err"},   32'(bus.frame_err),   32'd0);
        chk({tag, "_valid"}, 32'(bus.frame_valid), 32'd0);
        chk({tag, "_ovr"},   32'(bus.overrun),     32'd0);
    endtask

    initial begin
        logic [6:0] s;
        logic [3:0] e;
        int         sel;

        rst_n           = 1'b0;
        bus.seg         = '0;
        bus.dig_en      = '0;
        bus.frame_ready = 1'b0;
        model_reset();
        #12;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic scan 0,1,2,3
        hold(7'h7E, 4'b0001, 5, 1'b0);
        hold(7'h30, 4'b0010, 5, 1'b0);
        hold(7'h6D, 4'b0100, 5, 1'b0);
        hold(7'h79, 4'b1000, 5, 1'b0);
        chk("scan_bcd",   32'(bus.frame_bcd),   32'h3210);
        chk("scan_err",   32'(bus.frame_err),   32'h0);
        chk("scan_valid", 32'(bus.frame_valid), 32'd1);
        cyc(7'h00, 4'b0000, 1'b1);
        chk("accept_valid", 32'(bus.frame_valid), 32'd0);

        // Short glitch, blank and error patterns
        hold(7'h7B, 4'b0001, 2, 1'b0);
        hold(7'h00, 4'b0010, 4, 1'b0);
        hold(7'h12, 4'b0100, 4, 1'b0);
        hold(7'h79, 4'b1000, 4, 1'b0);
        chk("glitch_valid", 32'(bus.frame_valid), 32'd0);
        hold(7'h7B, 4'b0001, 5, 1'b0);
        chk("mix_bcd",   32'(bus.frame_bcd),   32'h3FE9);
        chk("mix_err",   32'(bus.frame_err),   32'b0100);
        chk("mix_valid", 32'(bus.frame_valid), 32'd1);

        // Backpressure: second frame is dropped
        ovr_cnt = 0;
        hold(7'h7E, 4'b0001, 5, 1'b0);
        hold(7'h7E, 4'b0010, 5, 1'b0);
        hold(7'h7E, 4'b0100, 5, 1'b0);
        hold(7'h7E, 4'b1000, 5, 1'b0);
        chk("bp_bcd",    32'(bus.frame_bcd),   32'h3FE9);
        chk("bp_ovr_n",  32'(ovr_cnt),         32'd1);
        cyc(7'h00, 4'b0000, 1'b1);
        chk("bp_release", 32'(bus.frame_valid), 32'd0);

        // Multi-hot enable never captures
        hold(7'h7E, 4'b0011, 10, 1'b0);
        hold(7'h30, 4'b0100, 4, 1'b0);
        hold(7'h30, 4'b1000, 4, 1'b0);
        chk("multihot_valid", 32'(bus.frame_valid), 32'd0);
        hold(7'h6D, 4'b0001, 4, 1'b0);
        hold(7'h6D, 4'b0010, 5, 1'b0);
        chk("fill_valid", 32'(bus.frame_valid), 32'd1);
        chk("fill_bcd",   32'(bus.frame_bcd),   32'h1122);

        // Asynchronous reset with 3 of 4 positions collected
        hold(7'h79, 4'b0001, 4, 1'b0);
        hold(7'h79, 4'b0010, 4, 1'b0);
        hold(7'h79, 4'b0100, 4, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        hold(7'h5B, 4'b0010, 5, 1'b0);
        hold(7'h5B, 4'b0100, 5, 1'b0);
        hold(7'h5B, 4'b1000, 5, 1'b0);
        chk("recollect_valid", 32'(bus.frame_valid), 32'd0);
        hold(7'h5B, 4'b0001, 5, 1'b0);
        chk("recollect_v1",  32'(bus.frame_valid), 32'd1);
        chk("recollect_bcd", 32'(bus.frame_bcd),   32'h5555);

        // Random scans with random backpressure
        for (int h = 0; h < 250; h++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7)      s = digit_pat[$urandom_range(0, 9)];
            else if (sel < 8) s = 7'h00;
            else              s = 7'($urandom);
            if ($urandom_range(0, 9) < 8) e = 4'd1 << $urandom_range(0, 3);
            else                          e = 4'($urandom);
            for (int c = 0; c < int'($urandom_range(1, 6)); c++)
                cyc(s, e, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
